// File: rtl/ovideo_tx_pkg.sv
// Shared constants and helpers for the OVIDEO transmit sequencer.
package ovideo_tx_pkg;

    localparam int unsigned W = 7;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_TRAIN    = 2'd1,
        ST_RUN      = 2'd2
    } state_e;

    localparam logic [W-1:0] TRAIN_PAT_DEF = 7'b1010101;
    localparam logic [W-1:0] IDLE_PAT_DEF  = 7'b1100011;

    // Advance a PRBS7 (x^7 + x^6 + 1) generator by one full 7-bit word.
    function automatic logic [W-1:0] prbs7_step(input logic [W-1:0] s);
        logic [W-1:0] r;
        r = s;
        for (int i = 0; i < int'(W); i++) begin
            r = {r[W-2:0], r[6] ^ r[5]};
        end
        return r;
    endfunction

endpackage

// File: rtl/ovideo_tx_fifo2.sv
// Two-entry FIFO; entry 0 always holds the head so the read side needs no pointer.
module ovideo_tx_fifo2 #(
    parameter int unsigned DW = 28
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] ent0_q, ent0_d;
    logic [DW-1:0] ent1_q, ent1_d;
    logic [1:0]    cnt_q, cnt_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = data_i;
                end else begin
                    ent1_d = data_i;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            // Occupancy unchanged; the new word lands behind whatever stays.
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = data_i;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o  = ent0_q;
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/ovideo_tx_ctrl.sv
// OVIDEO 7:1 serializer bank sequencer: reset hold, training word, then FIFO-fed user words.
// Define OVIDEO_TX_PRBS_EN to replace the fixed training word with a per-lane PRBS7 sequence.
module ovideo_tx_ctrl
    import ovideo_tx_pkg::*;
#(
    parameter int unsigned  LANES     = 4,
    parameter int unsigned  RST_CYC   = 16,
    parameter int unsigned  TRAIN_CYC = 64,
    parameter logic [W-1:0] TRAIN_PAT = TRAIN_PAT_DEF,
    parameter logic [W-1:0] IDLE_PAT  = IDLE_PAT_DEF
) (
    input  logic               clk_i,
    input  logic               nrst_i,
    input  logic               en_i,
    input  logic [LANES*W-1:0] s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic               ser_rst_o,
    output logic [LANES*W-1:0] ser_d_o,
    output logic [1:0]         state_o,
    output logic               underflow_o,
    output logic [7:0]         uf_cnt_o
);

    localparam int unsigned DW  = LANES * W;
    localparam int unsigned RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int unsigned TCW = $clog2(TRAIN_CYC + 1);

    state_e          state_q, state_d;
    logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TCW-1:0]  train_cnt_q, train_cnt_d;
    logic            ser_rst_q, ser_rst_d;
    logic [DW-1:0]   ser_d_q, ser_d_d;
    logic            ready_q, ready_d;
    logic            underflow_q, underflow_d;
    logic [7:0]      uf_cnt_q, uf_cnt_d;

    logic            push_c;
    logic            pop_c;
    logic            run_active_c;
    logic            train_done_c;
    logic            full_nxt_c;
    logic [DW-1:0]   train_word_c;
    logic [DW-1:0]   fifo_head;
    logic            fifo_full;
    logic            fifo_empty;

    ovideo_tx_fifo2 #(
        .DW (DW)
    ) u_fifo (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  (s_data_i),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef OVIDEO_TX_PRBS_EN
    logic [DW-1:0] lfsr_q, lfsr_d;

    // Seed on the cycle that enters TRAIN, then free-run while TRAIN holds.
    always_comb begin
        train_word_c = '0;
        lfsr_d       = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            train_word_c[k*W +: W] = (state_q == ST_TRAIN) ? lfsr_q[k*W +: W]
                                                           : (7'h7F ^ W'(k));
            lfsr_d[k*W +: W] = prbs7_step(train_word_c[k*W +: W]);
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign train_word_c = {LANES{TRAIN_PAT}};
`endif

    assign push_c       = s_valid_i && ready_q;
    assign run_active_c = (state_q == ST_RUN) && en_i;
    assign train_done_c = (train_cnt_q >= TCW'(TRAIN_CYC - 1));

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        train_cnt_d = train_cnt_q;
        ser_rst_d   = ser_rst_q;
        ser_d_d     = ser_d_q;
        underflow_d = 1'b0;
        uf_cnt_d    = uf_cnt_q;
        pop_c       = 1'b0;

        case (state_q)
            ST_RST_HOLD: begin
                ser_rst_d = 1'b1;
                rst_cnt_d = rst_cnt_q + RCW'(1);
                if (rst_cnt_q == RCW'(RST_CYC - 1)) begin
                    state_d     = ST_TRAIN;
                    ser_rst_d   = 1'b0;
                    rst_cnt_d   = '0;
                    train_cnt_d = '0;
                end
            end
            ST_TRAIN: begin
                if (train_cnt_q != TCW'(TRAIN_CYC)) begin
                    train_cnt_d = train_cnt_q + TCW'(1);
                end
                if (train_done_c && en_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en_i) begin
                    state_d     = ST_TRAIN;
                    train_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_RST_HOLD;
                ser_rst_d = 1'b1;
                rst_cnt_d = '0;
            end
        endcase

        // Lane word for the next cycle: user data/idle only while RUN persists.
        if (run_active_c) begin
            if (!fifo_empty) begin
                pop_c   = 1'b1;
                ser_d_d = fifo_head;
            end else begin
                ser_d_d     = {LANES{IDLE_PAT}};
                underflow_d = 1'b1;
                if (uf_cnt_q != 8'hFF) begin
                    uf_cnt_d = uf_cnt_q + 8'd1;
                end
            end
        end else if (state_d == ST_RST_HOLD) begin
            ser_d_d = '0;
        end else begin
            ser_d_d = train_word_c;
        end
    end

    // Ready reflects next-cycle occupancy so it never depends on s_valid_i combinationally.
    assign full_nxt_c = (fifo_full && !pop_c) ||
                        (!fifo_full && !fifo_empty && push_c && !pop_c);
    assign ready_d    = (state_d != ST_RST_HOLD) && !full_nxt_c;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= ST_RST_HOLD;
            rst_cnt_q   <= '0;
            train_cnt_q <= '0;
            ser_rst_q   <= 1'b1;
            ser_d_q     <= '0;
            ready_q     <= 1'b0;
            underflow_q <= 1'b0;
            uf_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            train_cnt_q <= train_cnt_d;
            ser_rst_q   <= ser_rst_d;
            ser_d_q     <= ser_d_d;
            ready_q     <= ready_d;
            underflow_q <= underflow_d;
            uf_cnt_q    <= uf_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign ser_rst_o   = ser_rst_q;
    assign ser_d_o     = ser_d_q;
    assign s_ready_o   = ready_q;
    assign underflow_o = underflow_q;
    assign uf_cnt_o    = uf_cnt_q;

endmodule

// File: tb/tb_ovideo_tx_ctrl.sv
// Self-checking bench for ovideo_tx_ctrl against a queue-based behavioural model.
module tb_ovideo_tx_ctrl;

    localparam int unsigned LANES     = 4;
    localparam int unsigned RST_CYC   = 16;
    localparam int unsigned TRAIN_CYC = 64;
    localparam int unsigned DW        = LANES * 7;
    localparam int unsigned VW        = DW + 13;
    localparam logic [6:0]  TRAIN_W   = 7'b1010101;
    localparam logic [6:0]  IDLE_W    = 7'b1100011;

    logic          clk_i = 1'b0;
    logic          nrst_i;
    logic          en_i;
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic          ser_rst_o;
    logic [DW-1:0] ser_d_o;
    logic [1:0]    state_o;
    logic          underflow_o;
    logic [7:0]    uf_cnt_o;

    ovideo_tx_ctrl #(
        .LANES     (LANES),
        .RST_CYC   (RST_CYC),
        .TRAIN_CYC (TRAIN_CYC)
    ) dut (
        .clk_i       (clk_i),
        .nrst_i      (nrst_i),
        .en_i        (en_i),
        .s_data_i    (s_data_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .ser_rst_o   (ser_rst_o),
        .ser_d_o     (ser_d_o),
        .state_o     (state_o),
        .underflow_o (underflow_o),
        .uf_cnt_o    (uf_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_no  = 0;
    int t_train  = -1;

    // Behavioural model: phase, elapsed cycles, and the queue of accepted words.
    int            m_phase;
    int            m_edges;
    int            m_tcyc;
    logic [DW-1:0] m_q[$];
    logic          m_rst;
    logic [DW-1:0] m_d;
    logic          m_rdy;
    logic          m_uf;
    int            m_ufc;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {state_o, ser_rst_o, s_ready_o, underflow_o, uf_cnt_o, ser_d_o};

    function automatic logic [VW-1:0] exp_vec();
        return {2'(m_phase), m_rst, m_rdy, m_uf, 8'(m_ufc), m_d};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_edges = 0;
        m_tcyc  = 0;
        m_q.delete();
        m_rst   = 1'b1;
        m_d     = '0;
        m_rdy   = 1'b0;
        m_uf    = 1'b0;
        m_ufc   = 0;
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then settle.
    task automatic cycle();
        logic          push;
        logic [DW-1:0] pd;
        @(posedge clk_i);
        edge_no++;
        if (!nrst_i) begin
            model_reset();
            #1;
            return;
        end
        push = s_valid_i && m_rdy;
        pd   = s_data_i;
        m_uf = 1'b0;
        case (m_phase)
            0: begin
                m_edges++;
                if (m_edges >= int'(RST_CYC)) begin
                    m_phase = 1;
                    m_tcyc  = 0;
                    m_rst   = 1'b0;
                    m_d     = {LANES{TRAIN_W}};
                end else begin
                    m_d = '0;
                end
            end
            1: begin
                m_tcyc++;
                m_d = {LANES{TRAIN_W}};
                if (m_tcyc >= int'(TRAIN_CYC) && en_i) m_phase = 2;
            end
            default: begin
                if (!en_i) begin
                    m_phase = 1;
                    m_tcyc  = 0;
                    m_d     = {LANES{TRAIN_W}};
                end else if (m_q.size() > 0) begin
                    m_d = m_q.pop_front();
                end else begin
                    m_d  = {LANES{IDLE_W}};
                    m_uf = 1'b1;
                    if (m_ufc < 255) m_ufc++;
                end
            end
        endcase
        if (push) m_q.push_back(pd);
        m_rdy = (m_phase != 0) && (m_q.size() < 2);
        #1;
    endtask

    task automatic test_reset();
        nrst_i    = 1'b0;
        en_i      = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        model_reset();
        #12;
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_vals: got %h exp %h", dut_vec, exp_vec());
        else n_pass++;
        @(negedge clk_i);
        nrst_i  = 1'b1;
        edge_no = 0;
        for (int i = 0; i < int'(RST_CYC) + 4; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL rst_hold e%0d: got %h exp %h", edge_no, dut_vec, exp_vec());
            else n_pass++;
            if (state_o === 2'd1 && t_train < 0) t_train = edge_no;
        end
        n_checks++;
        if (t_train != int'(RST_CYC)) $display("FAIL rst_len: got %0d exp %0d", t_train, RST_CYC);
        else n_pass++;
    endtask

    task automatic test_train_to_run();
        int t_run;
        t_run = -1;
        for (int i = 0; i < int'(TRAIN_CYC) + 10; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL train e%0d: got %h exp %h", edge_no, dut_vec, exp_vec());
            else n_pass++;
            if (state_o === 2'd2 && t_run < 0) t_run = edge_no;
        end
        n_checks++;
        if (t_run - t_train != int'(TRAIN_CYC)) $display("FAIL train_len: got %0d exp %0d", t_run - t_train, TRAIN_CYC);
        else n_pass++;
    endtask

    task automatic test_stream();
        int   w;
        int   guard;
        int   uf_in;
        logic acc;
        logic seen1;
        logic seen5;
        w = 1; guard = 0; uf_in = 0; seen1 = 1'b0; seen5 = 1'b0;
        while (guard < 30) begin
            if (w <= 5) begin
                s_valid_i = 1'b1;
                s_data_i  = {LANES{7'(w)}};
            end else begin
                s_valid_i = 1'b0;
            end
            acc = s_valid_i && m_rdy;
            cycle();
            guard++;
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL stream e%0d: got %h exp %h", edge_no, dut_vec, exp_vec());
            else n_pass++;
            if (ser_d_o === {LANES{7'd1}}) seen1 = 1'b1;
            if (seen1 && !seen5 && underflow_o) uf_in++;
            if (ser_d_o === {LANES{7'd5}}) seen5 = 1'b1;
            if (acc) w++;
            if (w > 5 && seen5) break;
        end
        s_valid_i = 1'b0;
        n_checks++;
        if (!(seen5 && uf_in == 0)) $display("FAIL stream_no_uf: seen5=%0b uf=%0d exp seen5=1 uf=0", seen5, uf_in);
        else n_pass++;
    endtask

    task automatic test_underflow_gap();
        int         n_uf;
        int         n_idle;
        logic [7:0] c0;
        logic [6:0] wv[4];
        for (int i = 0; i < 4; i++) wv[i] = 7'($urandom_range(8, 100));
        n_uf = 0; n_idle = 0; c0 = '0;
        for (int i = 0; i < 8; i++) begin
            s_valid_i = (i < 2 || i == 5 || i == 6);
            s_data_i  = {LANES{wv[(i < 2) ? i : i - 3]}};
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL gap e%0d: got %h exp %h", edge_no, dut_vec, exp_vec());
            else n_pass++;
            if (i == 0) c0 = uf_cnt_o;
            else if (underflow_o === 1'b1 && ser_d_o === {LANES{IDLE_W}}) begin
                n_uf++;
                n_idle++;
            end
            if (i == 7) begin
                n_checks++;
                if (n_idle != 3 || uf_cnt_o - c0 != 8'd3)
                    $display("FAIL gap_count: idle=%0d dcnt=%0d exp 3 and 3", n_idle, uf_cnt_o - c0);
                else n_pass++;
            end
        end
        s_valid_i = 1'b0;
        n_checks++;
        if (n_uf != 3) $display("FAIL gap_uf: got %0d exp 3", n_uf);
        else n_pass++;
    endtask

    task automatic test_full_hold();
        logic [DW-1:0] d[3];
        logic [DW-1:0] got[2];
        int            ng;
        for (int i = 0; i < 3; i++) d[i] = DW'($urandom);
        ng = 0;
        en_i      = 1'b0;
        s_valid_i = 1'b0;
        cycle();
        n_checks++;
        if (dut_vec !== exp_vec() || state_o !== 2'd1) $display("FAIL to_train: got %h exp %h", dut_vec, exp_vec());
        else n_pass++;
        s_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data_i = d[(i < 2) ? i : 2];
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL fill e%0d: got %h exp %h", edge_no, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (s_ready_o !== 1'b0) $display("FAIL full_ready: got %b exp 0", s_ready_o);
        else n_pass++;
        s_valid_i = 1'b0;
        en_i      = 1'b1;
        for (int i = 0; i < int'(TRAIN_CYC) + 6; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL drain e%0d: got %h exp %h", edge_no, dut_vec, exp_vec());
            else n_pass++;
            if (state_o === 2'd2 && ser_d_o !== {LANES{TRAIN_W}} && ng < 2) begin
                got[ng] = ser_d_o;
                ng++;
            end
        end
        n_checks++;
        if (ng != 2 || got[0] !== d[0] || got[1] !== d[1])
            $display("FAIL full_order: n=%0d got %h %h exp %h %h", ng, got[0], got[1], d[0], d[1]);
        else n_pass++;
    endtask

    task automatic test_en_drop_reset();
        logic [DW-1:0] e[2];
        logic [DW-1:0] got[2];
        int            ng;
        e[0] = DW'($urandom);
        e[1] = DW'($urandom);
        ng = 0;
        s_valid_i = 1'b1;
        s_data_i  = e[0];
        cycle();
        en_i     = 1'b0;
        s_data_i = e[1];
        cycle();
        s_valid_i = 1'b0;
        n_checks++;
        if (dut_vec !== exp_vec() || state_o !== 2'd1) $display("FAIL en_drop: got %h exp %h", dut_vec, exp_vec());
        else n_pass++;
        for (int i = 0; i < 4; i++) cycle();
        en_i = 1'b1;
        for (int i = 0; i < int'(TRAIN_CYC) + 4; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL kept e%0d: got %h exp %h", edge_no, dut_vec, exp_vec());
            else n_pass++;
            if (state_o === 2'd2 && ser_d_o !== {LANES{TRAIN_W}} && ng < 2) begin
                got[ng] = ser_d_o;
                ng++;
            end
        end
        n_checks++;
        if (ng != 2 || got[0] !== e[0] || got[1] !== e[1])
            $display("FAIL kept_order: n=%0d got %h %h exp %h %h", ng, got[0], got[1], e[0], e[1]);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            s_valid_i = 1'($urandom_range(0, 1));
            s_data_i  = DW'($urandom);
            cycle();
        end
        #3;
        nrst_i = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== {2'd0, 1'b1, 1'b0, 1'b0, 8'd0, {DW{1'b0}}})
            $display("FAIL async_rst: got %h exp %h", dut_vec, {2'd0, 1'b1, 1'b0, 1'b0, 8'd0, {DW{1'b0}}});
        else n_pass++;
        s_valid_i = 1'b0;
        @(negedge clk_i);
        nrst_i = 1'b1;
        for (int i = 0; i < int'(RST_CYC) + 3; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL rerelease e%0d: got %h exp %h", edge_no, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en_i      = ($urandom_range(0, 99) < 97);
            s_valid_i = ($urandom_range(0, 9) < 6);
            s_data_i  = DW'($urandom);
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL random e%0d: got %h exp %h", edge_no, dut_vec, exp_vec());
            else n_pass++;
        end
        s_valid_i = 1'b0;
        en_i      = 1'b1;
    endtask

    task automatic test_uf_saturate();
        for (int i = 0; i < int'(TRAIN_CYC) + 270; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL sat e%0d: got %h exp %h", edge_no, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (uf_cnt_o !== 8'd255 || underflow_o !== 1'b1)
            $display("FAIL uf_sat: got cnt=%0d uf=%b exp cnt=255 uf=1", uf_cnt_o, underflow_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_train_to_run();
        test_stream();
        test_underflow_gap();
        test_full_hold();
        test_en_drop_reset();
        test_random();
        test_uf_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
